// File: rtl/systolic_feeder.sv
// Feeds A column slices and B row slices into a systolic MAC array with per-lane skew,
// and generates the accumulator-clear and tile-result-ready pulses for MAC(0,0).
module systolic_feeder #(
  parameter int IN_WIDTH = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int K        = 4,
  parameter int MULT_LAT = 3,
  parameter int ADD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*IN_WIDTH-1:0] a_data,
  input  logic [COLS*IN_WIDTH-1:0] b_data,
  output logic [ROWS*IN_WIDTH-1:0] row_data_out,
  output logic [COLS*IN_WIDTH-1:0] col_data_out,
  output logic                     rst_accumulator_out,
  output logic                     stream_out_rdy_out,
  output logic                     busy
);

  // Cycles needed for the last beat to ripple through the skew and the MAC pipeline.
  localparam int D     = MULT_LAT + ADD_LAT + ROWS + COLS - 1;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int DW    = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             accept;
  logic             last_beat;
  logic             drain_done;
  logic             rst_acc_q;
  logic             stream_rdy_q;

  // Handshake: a beat transfers when in_valid && in_ready; in_ready depends on state only.
  assign in_ready   = (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt == CNT_W'(K - 1));
  assign drain_done = (state == DRAIN) && (drain_cnt == DW'(D - 1));
  assign busy       = (state != IDLE);

  assign rst_accumulator_out = rst_acc_q;
  assign stream_out_rdy_out  = stream_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: begin
        if (accept && last_beat) state_nxt = DRAIN;
        else if (accept)         state_nxt = LOAD;
      end
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      drain_cnt    <= '0;
      rst_acc_q    <= 1'b0;
      stream_rdy_q <= 1'b0;
    end else begin
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      drain_cnt    <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      rst_acc_q    <= accept && (beat_cnt == '0);
      stream_rdy_q <= drain_done;
    end
  end

  // Lane r is delayed by r+1 stages; stage 0 takes zero whenever no beat is accepted.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [IN_WIDTH-1:0] sr [0:r];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) sr[i] <= '0;
      end else begin
        sr[0] <= accept ? a_data[r*IN_WIDTH +: IN_WIDTH] : '0;
        for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
      end
    end
    assign row_data_out[r*IN_WIDTH +: IN_WIDTH] = sr[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [IN_WIDTH-1:0] sr [0:c];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) sr[i] <= '0;
      end else begin
        sr[0] <= accept ? b_data[c*IN_WIDTH +: IN_WIDTH] : '0;
        for (int i = 1; i <= c; i++) sr[i] <= sr[i-1];
      end
    end
    assign col_data_out[c*IN_WIDTH +: IN_WIDTH] = sr[c];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed scenarios plus random traffic, checked every cycle
// against an acceptance-timeline model (what was accepted when, and when each tile ends).
module tb_systolic_feeder;

  localparam int W        = 8;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int K        = 4;
  localparam int MULT_LAT = 3;
  localparam int ADD_LAT  = 1;
  localparam int D        = MULT_LAT + ADD_LAT + ROWS + COLS - 1;
  localparam int AW       = ROWS * W;
  localparam int BW       = COLS * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a_data;
  logic [BW-1:0] b_data;
  logic [AW-1:0] row_data_out;
  logic [BW-1:0] col_data_out;
  logic          rst_accumulator_out;
  logic          stream_out_rdy_out;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Model: beats accepted per cycle, tile start cycles, expected result pulses.
  logic [AW-1:0] a_hist [int];
  logic [BW-1:0] b_hist [int];
  bit            first_hist [int];
  bit            pulse_hist [int];
  int            beats;
  int            drain_start;
  int            drain_end;

  systolic_feeder #(
    .IN_WIDTH(W), .ROWS(ROWS), .COLS(COLS), .K(K), .MULT_LAT(MULT_LAT), .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_data(a_data),
    .b_data(b_data),
    .row_data_out(row_data_out),
    .col_data_out(col_data_out),
    .rst_accumulator_out(rst_accumulator_out),
    .stream_out_rdy_out(stream_out_rdy_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    a_hist.delete();
    b_hist.delete();
    first_hist.delete();
    pulse_hist.delete();
    beats       = 0;
    drain_start = -1;
    drain_end   = -1;
    cyc         = -1;
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, update the model.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic r);
    logic [AW-1:0] er;
    logic [BW-1:0] ec;
    logic [AW-1:0] ta;
    logic [BW-1:0] tb;
    logic          in_drain;
    logic          ready_e;
    logic          busy_e;
    rst      = r;
    in_valid = v;
    a_data   = a;
    b_data   = b;
    @(negedge clk);
    in_drain = (cyc >= drain_start) && (cyc < drain_end);
    ready_e  = !in_drain;
    busy_e   = (beats > 0) || in_drain;
    er = '0;
    ec = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (a_hist.exists(cyc - 1 - i)) begin
        ta = a_hist[cyc - 1 - i];
        er[i*W +: W] = ta[i*W +: W];
      end
    end
    for (int i = 0; i < COLS; i++) begin
      if (b_hist.exists(cyc - 1 - i)) begin
        tb = b_hist[cyc - 1 - i];
        ec[i*W +: W] = tb[i*W +: W];
      end
    end
    chk("row_data_out", 64'(row_data_out), 64'(er));
    chk("col_data_out", 64'(col_data_out), 64'(ec));
    chk("rst_accumulator_out", 64'(rst_accumulator_out), 64'(first_hist.exists(cyc - 1)));
    chk("stream_out_rdy_out", 64'(stream_out_rdy_out), 64'(pulse_hist.exists(cyc)));
    chk("in_ready", 64'(in_ready), 64'(ready_e));
    chk("busy", 64'(busy), 64'(busy_e));
    if (r) begin
      model_clear();
    end else if (v && ready_e) begin
      a_hist[cyc] = a;
      b_hist[cyc] = b;
      if (beats == 0) first_hist[cyc] = 1'b1;
      beats++;
      if (beats == K) begin
        beats       = 0;
        drain_start = cyc + 1;
        drain_end   = cyc + 1 + D;
        pulse_hist[cyc + 1 + D] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset2();
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_data   = '0;
    b_data   = '0;
    model_clear();
    @(posedge clk);
    #1;
    // Reset held for two edges; the second cycle already shows post-reset outputs.
    step(1'b0, '0, '0, 1'b1);

    // Single beat with known lanes; inputs after it carry junk that must not be sampled.
    step(1'b1, 32'h04030201, 32'h08070605, 1'b0);
    repeat (8) step(1'b0, $urandom, $urandom, 1'b0);
    reset2();

    // Full tile back-to-back, then the whole drain with junk offered while not ready.
    for (int i = 0; i < K; i++) step(1'b1, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 14; i++) step(i < 11, $urandom, $urandom, 1'b0);
    reset2();

    // Bubble at cycle 2.
    step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b0, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b0);
    repeat (14) step(1'b0, '0, '0, 1'b0);
    reset2();

    // Reset mid-drain at cycle 6: tile abandoned, no pulse, no stale lane data.
    for (int i = 0; i < K; i++) step(1'b1, $urandom, $urandom, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, $urandom, $urandom, 1'b1);
    repeat (20) step(1'b0, $urandom, $urandom, 1'b0);
    reset2();

    // Back-to-back tiles: valid held from cycle 10, accepted on the pulse cycle 15.
    for (int i = 0; i < K; i++) step(1'b1, $urandom, $urandom, 1'b0);
    repeat (6) step(1'b0, '0, '0, 1'b0);
    repeat (9) step(1'b1, $urandom, $urandom, 1'b0);
    repeat (16) step(1'b0, '0, '0, 1'b0);
    reset2();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 99) == 0);
    end
    repeat (D + 2) step(1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- IN_WIDTH, 8, element width in bits
- ROWS, 4, array rows (A lanes)
- COLS, 4, array columns (B lanes)
- K, 4, beats per tile (inner dimension)
- MULT_LAT, 3, MAC multiplier latency in cycles
- ADD_LAT, 1, MAC adder latency in cycles
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, A/B beat valid
- in_ready, out, 1, beat accepted when in_valid && in_ready
- a_data, in, ROWS*IN_WIDTH, one A column slice; lane r is bits [r*IN_WIDTH +: IN_WIDTH]
- b_data, in, COLS*IN_WIDTH, one B row slice; lane c is bits [c*IN_WIDTH +: IN_WIDTH]
- row_data_out, out, ROWS*IN_WIDTH, skewed A lanes to the array's left edge
- col_data_out, out, COLS*IN_WIDTH, skewed B lanes to the array's top edge
- rst_accumulator_out, out, 1, accumulator-clear pulse into MAC(0,0)
- stream_out_rdy_out, out, 1, tile-result-ready pulse into MAC(0,0)
- busy, out, 1, high whenever the state is not IDLE
REQ-003 Reset is rst, synchronous, active-high; the clock is clk.

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD and DRAIN.
REQ-005 IDLE -> LOAD on an accepted beat when K>1; IDLE -> DRAIN on an accepted beat when K==1.
REQ-006 LOAD -> DRAIN on the accepted beat that brings the count of accepted beats to K.
REQ-007 DRAIN -> IDLE after exactly D = MULT_LAT+ADD_LAT+ROWS+COLS-1 cycles in DRAIN.
REQ-008 in_ready SHALL be 1 in IDLE and LOAD and 0 in DRAIN; it is a combinational function of state only.
REQ-009 The beat counter (0..K-1) SHALL increment only on accepted beats, wrap to 0 on the K-th beat, and hold during bubbles.
REQ-010 Lane skew: A lane r accepted at cycle t SHALL appear on row_data_out lane r at cycle t+1+r; B lane c accepted at cycle t SHALL appear on col_data_out lane c at cycle t+1+c. Skew is built from per-lane shift registers of depth lane+1.
REQ-011 In any cycle without an accepted beat (bubble, IDLE or DRAIN), zero SHALL enter lane stage 0, so every output lane carries 0 except delayed valid data.
REQ-012 rst_accumulator_out SHALL be a 1-cycle pulse at t0+1, where t0 is the acceptance cycle of the first beat of a tile; it is aligned with lane-0 data and is otherwise 0.
REQ-013 stream_out_rdy_out SHALL be registered and pulse for exactly 1 cycle at tL+1+D, where tL is the acceptance cycle of the tile's last beat; this is the first cycle back in IDLE.
REQ-014 A beat offered in the same cycle as the stream_out_rdy_out pulse (IDLE) SHALL be accepted and starts the next tile. Its rst_accumulator_out pulse follows one cycle later.
REQ-015 in_valid while in DRAIN SHALL be ignored; a_data and b_data are not sampled.
REQ-016 Data values pass through unmodified: no arithmetic, no width change.
REQ-017 busy = (state != IDLE).

Reset
REQ-018 While rst is high at a clock edge, the block SHALL go to IDLE, clear the beat counter and drain counter, and zero all skew registers.
REQ-019 After such an edge, all outputs SHALL be 0 except in_ready = 1.
REQ-020 Reset mid-tile (LOAD or DRAIN) SHALL abandon the tile: no stream_out_rdy_out pulse, and no stale lane data emerges afterwards.

Verification (ROWS=COLS=K=4, MULT_LAT=3, ADD_LAT=1, so D=11; cycle 0 is the first cycle after reset is released)
REQ-021 Reset: hold rst for 2 cycles -> all data outputs, rst_accumulator_out, stream_out_rdy_out and busy are 0; in_ready is 1.
REQ-022 Single beat: a lanes={1,2,3,4}, b lanes={5,6,7,8} accepted at cycle 0 -> row lane r = r+1 only at cycle 1+r; col lane c = c+5 only at cycle 1+c; 0 elsewhere; rst_accumulator_out = 1 at cycle 1 only.
REQ-023 Full tile: beats accepted back-to-back at cycles 0..3 -> in_ready = 0 during cycles 4..14; stream_out_rdy_out = 1 at cycle 15 only; busy = 1 during cycles 1..14.
REQ-024 Bubble: in_valid = 0 at cycle 2 and beats accepted at cycles 0,1,3,4 -> all lanes carry 0 for the skewed slot of cycle 2; stream_out_rdy_out = 1 at cycle 16.
REQ-025 Reset mid-drain: rst asserted at cycle 6 of the full-tile scenario -> all outputs 0 at cycle 7; no stream_out_rdy_out pulse ever; in_ready = 1 from cycle 7.
REQ-026 Back-to-back tiles: a new beat held valid from cycle 10 -> accepted at cycle 15; rst_accumulator_out = 1 at cycle 16; the second stream_out_rdy_out pulse occurs at cycle 30.
